tile_swap_ctrl: RTL and testbench

Controller that shares the 64x5 puzzle tile RAM between the VGA renderer and the game logic. The renderer has absolute priority on the RAM read port. Game logic issues tile-swap requests, and the controller sequences them as read A, read B, write A, write B on the RAM's separate read and write ports. It sits between the renderer/game FSM and the tile RAM instance.

---
 rtl/tile_swap_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_tile_swap_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_swap_ctrl.sv
// Arbitrates the 64x5 tile RAM between the VGA renderer (read priority) and game-logic tile swaps.
// Optional build macro ADJ_CHECK_EN: reject swaps of cells that are not orthogonally adjacent.
module tile_swap_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 5,
    parameter int GRID_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              vga_re,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    input  logic              swap_req,
    input  logic [ADDR_W-1:0] swap_a,
    input  logic [ADDR_W-1:0] swap_b,
    output logic              swap_busy,
    output logic              swap_done,
    output logic              swap_err,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

`ifdef ADJ_CHECK_EN
    localparam bit ADJ_ON = 1'b1;
`else
    localparam bit ADJ_ON = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] GRID_A = ADDR_W'(GRID_W);
    localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_CAP_A = 3'd2,
        ST_RD_B  = 3'd3,
        ST_CAP_B = 3'd4,
        ST_WR_A  = 3'd5,
        ST_WR_B  = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr_a;
    logic [ADDR_W-1:0]   r_addr_b;
    logic [DATA_W-1:0]   r_tmp_a;
    logic [DATA_W-1:0]   r_tmp_b;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_vga_valid;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_waddr;
    logic [DATA_W-1:0]   r_mem_din;

    logic                w_mem_re;
    logic [ADDR_W-1:0]   w_mem_raddr;
    logic                w_adjacent;
    logic                w_reject;

    // Orthogonal neighbours: one row apart, or one column apart within the same row.
    function automatic logic is_adjacent(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        logic [ADDR_W-1:0] diff;
        diff = (a > b) ? (a - b) : (b - a);
        return (diff == GRID_A) || ((diff == ONE_A) && ((a / GRID_A) == (b / GRID_A)));
    endfunction

    assign w_adjacent = is_adjacent(swap_a, swap_b);
    assign w_reject   = ADJ_ON && (swap_a != swap_b) && !w_adjacent;

    // Read-port mux: renderer always wins, FSM reads only in its RD states.
    always_comb begin
        w_mem_re    = 1'b0;
        w_mem_raddr = '0;
        if (vga_re) begin
            w_mem_re    = 1'b1;
            w_mem_raddr = vga_addr;
        end else if (r_state == ST_RD_A) begin
            w_mem_re    = 1'b1;
            w_mem_raddr = r_addr_a;
        end else if (r_state == ST_RD_B) begin
            w_mem_re    = 1'b1;
            w_mem_raddr = r_addr_b;
        end else begin
            w_mem_re    = 1'b0;
            w_mem_raddr = '0;
        end
    end

    // Renderer data-valid tracks the RAM's one-cycle read latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_vga_valid <= 1'b0;
        end else begin
            r_vga_valid <= vga_re;
        end
    end

    // Swap sequencer; write-port outputs are registered alongside the state they belong to.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_tmp_a     <= '0;
            r_tmp_b     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_din   <= '0;
        end else begin
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_din   <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (swap_req) begin
                        r_addr_a <= swap_a;
                        r_addr_b <= swap_b;
                        if (swap_a == swap_b) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b1;
                        end else if (w_reject) begin
                            r_state <= ST_IDLE;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= ST_RD_A;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_RD_A: begin
                    if (!vga_re) begin
                        r_state <= ST_CAP_A;
                    end
                end
                ST_CAP_A: begin
                    r_tmp_a <= mem_dout;
                    r_state <= ST_RD_B;
                end
                ST_RD_B: begin
                    if (!vga_re) begin
                        r_state <= ST_CAP_B;
                    end
                end
                ST_CAP_B: begin
                    // mem_dout is B's value now; forward it straight into the first write.
                    r_tmp_b     <= mem_dout;
                    r_state     <= ST_WR_A;
                    r_mem_we    <= 1'b1;
                    r_mem_waddr <= r_addr_a;
                    r_mem_din   <= mem_dout;
                end
                ST_WR_A: begin
                    r_state     <= ST_WR_B;
                    r_mem_we    <= 1'b1;
                    r_mem_waddr <= r_addr_b;
                    r_mem_din   <= r_tmp_a;
                end
                ST_WR_B: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign vga_data  = mem_dout;
    assign vga_valid = r_vga_valid;
    assign swap_busy = r_busy;
    assign swap_done = r_done;
    assign swap_err  = r_err;
    assign mem_re    = w_mem_re;
    assign mem_raddr = w_mem_raddr;
    assign mem_we    = r_mem_we;
    assign mem_waddr = r_mem_waddr;
    assign mem_din   = r_mem_din;

endmodule

// File: tb/tb_tile_swap_ctrl.sv
// Self-checking bench for tile_swap_ctrl: behavioural RAM, array model of tile contents,
// latency predicted from the renderer request pattern.
module tb_tile_swap_ctrl;

`ifdef ADJ_CHECK_EN
    localparam bit ADJ = 1'b1;
`else
    localparam bit ADJ = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       vga_re = 1'b0;
    logic [5:0] vga_addr = 6'd0;
    logic [4:0] vga_data;
    logic       vga_valid;
    logic       swap_req = 1'b0;
    logic [5:0] swap_a = 6'd0;
    logic [5:0] swap_b = 6'd0;
    logic       swap_busy, swap_done, swap_err;
    logic       mem_re, mem_we;
    logic [5:0] mem_raddr, mem_waddr;
    logic [4:0] mem_din;
    logic [4:0] mem_dout;

    tile_swap_ctrl #(.ADDR_W(6), .DATA_W(5), .GRID_W(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .vga_re(vga_re), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
        .swap_req(swap_req), .swap_a(swap_a), .swap_b(swap_b),
        .swap_busy(swap_busy), .swap_done(swap_done), .swap_err(swap_err),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clock = ~clock;

    // Behavioural RAM: registered read, read-before-write.
    logic [4:0] ram [64];
    logic [4:0] ram_dout;
    logic [4:0] init_val [64];
    logic       load = 1'b0;
    always @(posedge clock) begin
        if (load) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_val[i];
        end else if (mem_we) begin
            ram[mem_waddr] <= mem_din;
        end
        if (mem_re) ram_dout <= ram[mem_raddr];
    end
    assign mem_dout = ram_dout;

    // Write log
    int         wr_cnt = 0;
    logic [5:0] wr_addr [512];
    logic [4:0] wr_data [512];
    always @(posedge clock) begin
        if (mem_we && wr_cnt < 512) begin
            wr_addr[wr_cnt] <= mem_waddr;
            wr_data[wr_cnt] <= mem_din;
            wr_cnt <= wr_cnt + 1;
        end
    end

    logic [4:0] model [64];
    logic       vpat [128];
    int passed = 0;
    int fails = 0;
    int total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit adjacent(input int a, input int b);
        int ra, rb, ca, cb;
        ra = a / 8; rb = b / 8; ca = a % 8; cb = b % 8;
        return ((ca == cb) && (ra - rb == 1 || rb - ra == 1)) ||
               ((ra == rb) && (ca - cb == 1 || cb - ca == 1));
    endfunction

    task automatic clear_vpat();
        for (int i = 0; i < 128; i++) vpat[i] = 1'b0;
    endtask

    task automatic vga_read(input logic [5:0] addr);
        vga_re = 1'b1;
        vga_addr = addr;
        @(negedge clock);
        vga_re = 1'b0;
        chk("rd_valid", 32'(vga_valid), 32'd1);
        chk("rd_data", 32'(vga_data), 32'(model[addr]));
    endtask

    // Issue one swap starting at a negedge, with vpat driving vga_re each cycle.
    task automatic run_swap(input logic [5:0] a, input logic [5:0] b, input bit poke);
        int t1, t2, done_at, err_at, last, base;
        bit same, rej, poke_eff;
        logic [5:0] c;
        logic [4:0] tmp;
        same = (a == b);
        rej = ADJ && !same && !adjacent(int'(a), int'(b));
        done_at = 0;
        err_at = 0;
        if (same) done_at = 1;
        else if (rej) err_at = 1;
        else begin
            t1 = 1;
            while (vpat[t1]) t1++;
            t2 = t1 + 2;
            while (vpat[t2]) t2++;
            done_at = t2 + 4;
        end
        last = ((done_at > err_at) ? done_at : err_at) + 2;
        poke_eff = poke && (done_at >= 3);
        c = 6'd0;
        while (c == a || c == b) c = c + 6'd1;
        base = wr_cnt;
        swap_req = 1'b1;
        swap_a = a;
        swap_b = b;
        vga_re = vpat[0];
        vga_addr = c;
        for (int k = 1; k <= last; k++) begin
            @(negedge clock);
            chk("vga_valid", 32'(vga_valid), 32'(vpat[k-1]));
            if (vpat[k-1]) chk("vga_data", 32'(vga_data), 32'(model[c]));
            chk("swap_done", 32'(swap_done), 32'(k == done_at));
            chk("swap_busy", 32'(swap_busy), 32'(k <= done_at));
            chk("swap_err", 32'(swap_err), 32'(k == err_at));
            swap_req = poke_eff && (k == 2);
            swap_a = 6'($urandom);
            swap_b = 6'($urandom);
            vga_re = vpat[k];
            #1;
            if (vga_re) begin
                chk("vga_mem_re", 32'(mem_re), 32'd1);
                chk("vga_raddr", 32'(mem_raddr), 32'(c));
            end
        end
        swap_req = 1'b0;
        vga_re = 1'b0;
        chk("wr_count", 32'(wr_cnt - base), (same || rej) ? 32'd0 : 32'd2);
        if (!same && !rej) begin
            chk("wr0_addr", 32'(wr_addr[base]), 32'(a));
            chk("wr0_data", 32'(wr_data[base]), 32'(model[b]));
            chk("wr1_addr", 32'(wr_addr[base+1]), 32'(b));
            chk("wr1_data", 32'(wr_data[base+1]), 32'(model[a]));
            tmp = model[a];
            model[a] = model[b];
            model[b] = tmp;
        end
        @(negedge clock);
        vga_read(a);
        vga_read(b);
    endtask

    initial begin
        int base, b_writes;
        logic [5:0] ra, rb;
        for (int i = 0; i < 64; i++) init_val[i] = 5'($urandom_range(0, 31));
        init_val[3] = 5'd7;
        init_val[4] = 5'd12;
        for (int i = 0; i < 64; i++) model[i] = init_val[i];
        clear_vpat();

        #2 reset_n = 1'b0;
        #1;
        chk("rst_done", 32'(swap_done), 32'd0);
        chk("rst_err", 32'(swap_err), 32'd0);
        chk("rst_busy", 32'(swap_busy), 32'd0);
        chk("rst_valid", 32'(vga_valid), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_re", 32'(mem_re), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        @(negedge clock);

        // Basic swap, then the same pair again with 3 renderer cycles landing in RD_A
        run_swap(6'd3, 6'd4, 1'b0);
        chk("basic_a", 32'(model[3]), 32'd12);
        chk("basic_b", 32'(model[4]), 32'd7);
        vpat[1] = 1'b1; vpat[2] = 1'b1; vpat[3] = 1'b1;
        run_swap(6'd3, 6'd4, 1'b1);
        clear_vpat();
        run_swap(6'd10, 6'd10, 1'b0);

        // Adjacency pairs (rejections only in the ADJ_CHECK_EN build)
        run_swap(6'd0, 6'd9, 1'b0);
        run_swap(6'd7, 6'd8, 1'b0);
        run_swap(6'd7, 6'd15, 1'b0);
        run_swap(6'd20, 6'd21, 1'b0);

        for (int n = 0; n < 20; n++) begin
            ra = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra + 6'd1;
                2: rb = ra + 6'd8;
                default: rb = 6'($urandom_range(0, 63));
            endcase
            clear_vpat();
            for (int i = 0; i <= 20; i++) vpat[i] = ($urandom_range(0, 9) < 3);
            run_swap(ra, rb, n[0]);
        end
        clear_vpat();

        // Reset while in WR_A with a renderer read in flight
        base = wr_cnt;
        swap_req = 1'b1; swap_a = 6'd5; swap_b = 6'd6; vga_re = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            swap_req = 1'b0;
            vga_re = (k == 4);
        end
        chk("pre_rst_we", 32'(mem_we), 32'd1);
        chk("pre_rst_valid", 32'(vga_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(swap_busy), 32'd0);
        chk("mid_rst_done", 32'(swap_done), 32'd0);
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_valid", 32'(vga_valid), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk("post_rst_done", 32'(swap_done), 32'd0);
            chk("post_rst_busy", 32'(swap_busy), 32'd0);
        end
        b_writes = 0;
        for (int i = base; i < wr_cnt; i++) if (wr_addr[i] == 6'd6) b_writes++;
        chk("no_wr_b", 32'(b_writes), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
